// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
// Shared RV32 register-file types for the writeback arbiter slice.
//   XLEN       : integer register width
//   NREGS      : architectural register count
//   regidx_t   : register index (x0..x31)
//   wb_entry_t : one pending register write {rdi, data}
// -----------------------------------------------------------------------------
package rv32_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    typedef logic [4:0] regidx_t;

    typedef struct packed {
        regidx_t           rdi;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // x0 is hardwired to zero, so writes and busy tracking skip it
    function automatic logic idx_writable(input regidx_t idx);
        return (idx != 5'd0);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the writeback, mul/div, issue/scoreboard and register-file write
// port signals of the writeback arbiter.
//   slave  : the arbiter (consumes writebacks, drives rf_* and status)
//   master : the surrounding pipeline / register file
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if;
    import rv32_pkg::*;

    // in-order pipeline writeback
    logic              wb_valid;
    regidx_t           wb_rdi;
    logic [XLEN-1:0]   wb_data;
    // mul/div result stream
    logic              md_valid;
    logic              md_ready;
    regidx_t           md_rdi;
    logic [XLEN-1:0]   md_data;
    // mul/div issue and scoreboard queries
    logic              issue_valid;
    regidx_t           issue_rdi;
    logic              issue_ready;
    regidx_t           rsi1;
    regidx_t           rsi2;
    logic              rs1_busy;
    logic              rs2_busy;
    logic [NREGS-1:0]  busy;
    // register file write port
    logic              rf_we;
    regidx_t           rf_rdi;
    logic [XLEN-1:0]   rf_rd;

    modport slave (
        input  wb_valid, wb_rdi, wb_data,
        input  md_valid, md_rdi, md_data,
        input  issue_valid, issue_rdi, rsi1, rsi2,
        output md_ready, issue_ready, rs1_busy, rs2_busy, busy,
        output rf_we, rf_rdi, rf_rd
    );

    modport master (
        output wb_valid, wb_rdi, wb_data,
        output md_valid, md_rdi, md_data,
        output issue_valid, issue_rdi, rsi1, rsi2,
        input  md_ready, issue_ready, rs1_busy, rs2_busy, busy,
        input  rf_we, rf_rdi, rf_rd
    );

endinterface

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of pending register writes.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : enqueue din (ignored when full)
//   pop/dout : dout is the head entry; pop dequeues it (ignored when empty)
//   full, empty : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module wb_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    wb_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic              push_s;
    logic              pop_s;

    // occupancy flags, guarded handshakes and head read
    always_comb begin
        full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        empty  = (wr_ptr_q == rd_ptr_q);
        push_s = push && !full;
        pop_s  = pop && !empty;
        dout   = mem_q[rd_ptr_q[AW-1:0]];
    end

    // storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    // read/write pointers, wrapping modulo 2*DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Merges the in-order pipeline writeback and the buffered mul/div results onto
// the single register-file write port, and keeps a busy scoreboard of
// destinations with a mul/div result still outstanding.
//   clk, rst : clock, synchronous active-high reset
//   bus      : regfile_wb_arbiter_if.slave
//              wb_*        pipeline writeback (highest priority, never stalled)
//              md_*        mul/div result stream, md_ready = FIFO not full
//              issue_*     mul/div issue handshake, gated by scoreboard/counter
//              rsi*/rs*_busy, busy  scoreboard lookups
//              rf_we/rf_rdi/rf_rd   registered write port
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import rv32_pkg::*;
#(
    parameter int MD_FIFO_DEPTH   = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic              fifo_full_s;
    logic              fifo_empty_s;
    wb_entry_t         fifo_din_s;
    wb_entry_t         fifo_head_s;
    logic              push_s;
    logic              pop_s;
    logic              pipe_sel_s;
    logic              md_ready_s;
    logic              issue_ready_s;
    logic              issue_fire_s;

    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [CNT_W-1:0]  outst_q;
    logic [CNT_W-1:0]  outst_d;
    logic              rf_we_q;
    logic              rf_we_d;
    regidx_t           rf_rdi_q;
    regidx_t           rf_rdi_d;
    logic [XLEN-1:0]   rf_rd_q;
    logic [XLEN-1:0]   rf_rd_d;

    wb_fifo #(
        .DEPTH (MD_FIFO_DEPTH)
    ) u_md_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (fifo_din_s),
        .dout  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // handshakes and arbitration select; ready outputs are forced low in reset
    always_comb begin
        md_ready_s    = !rst && !fifo_full_s;
        issue_ready_s = !rst && (outst_q < CNT_W'(MAX_OUTSTANDING)) && !busy_q[bus.issue_rdi];
        issue_fire_s  = bus.issue_valid && issue_ready_s;
        push_s        = bus.md_valid && md_ready_s;
        fifo_din_s    = '{rdi: bus.md_rdi, data: bus.md_data};
        // a pipeline write to x0 is treated as idle so the FIFO may drain
        pipe_sel_s    = bus.wb_valid && idx_writable(bus.wb_rdi);
        pop_s         = !rst && !pipe_sel_s && !fifo_empty_s;
    end

    // scoreboard next state: set on issue, clear on retire (never the same bit)
    always_comb begin
        busy_d = busy_q;
        if (issue_fire_s && idx_writable(bus.issue_rdi)) begin
            busy_d[bus.issue_rdi] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        if (pop_s && idx_writable(fifo_head_s.rdi)) begin
            busy_d[fifo_head_s.rdi] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // outstanding counter next state; simultaneous issue and retire cancel
    always_comb begin
        outst_d = outst_q;
        case ({issue_fire_s, pop_s})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01: begin
                if (outst_q != CNT_W'(0)) begin
                    outst_d = outst_q - CNT_W'(1);
                end else begin
                    outst_d = outst_q;
                end
            end
            default: outst_d = outst_q;
        endcase
    end

    // write-port next state; x0 mul/div results retire without a write
    always_comb begin
        rf_we_d  = 1'b0;
        rf_rdi_d = rf_rdi_q;
        rf_rd_d  = rf_rd_q;
        if (pipe_sel_s) begin
            rf_we_d  = 1'b1;
            rf_rdi_d = bus.wb_rdi;
            rf_rd_d  = bus.wb_data;
        end else if (pop_s) begin
            rf_we_d  = idx_writable(fifo_head_s.rdi);
            rf_rdi_d = fifo_head_s.rdi;
            rf_rd_d  = fifo_head_s.data;
        end else begin
            rf_we_d  = 1'b0;
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            outst_q  <= '0;
            rf_we_q  <= 1'b0;
            rf_rdi_q <= 5'd0;
            rf_rd_q  <= 32'd0;
        end else begin
            busy_q   <= busy_d;
            outst_q  <= outst_d;
            rf_we_q  <= rf_we_d;
            rf_rdi_q <= rf_rdi_d;
            rf_rd_q  <= rf_rd_d;
        end
    end

    // output mapping; busy bit 0 is held at zero so x0 never reports busy
    always_comb begin
        bus.md_ready    = md_ready_s;
        bus.issue_ready = issue_ready_s;
        bus.busy        = busy_q;
        bus.rs1_busy    = busy_q[bus.rsi1];
        bus.rs2_busy    = busy_q[bus.rsi2];
        bus.rf_we       = rf_we_q;
        bus.rf_rdi      = rf_rdi_q;
        bus.rf_rd       = rf_rd_q;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 more
// unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    regfile_wb_arbiter_if bus_if ();

    regfile_wb_arbiter #(
        .MD_FIFO_DEPTH   (2),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic expect_rf(input string tag, input logic we, input logic [4:0] rdi, input logic [31:0] rd);
        check_eq({tag, ".we"}, {31'd0, bus_if.rf_we}, {31'd0, we});
        if (we) begin
            check_eq({tag, ".rdi"}, {27'd0, bus_if.rf_rdi}, {27'd0, rdi});
            check_eq({tag, ".rd"}, bus_if.rf_rd, rd);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        bus_if.wb_valid    = 1'b0;
        bus_if.wb_rdi      = 5'd0;
        bus_if.wb_data     = 32'd0;
        bus_if.md_valid    = 1'b0;
        bus_if.md_rdi      = 5'd0;
        bus_if.md_data     = 32'd0;
        bus_if.issue_valid = 1'b0;
        bus_if.issue_rdi   = 5'd0;
        bus_if.rsi1        = 5'd0;
        bus_if.rsi2        = 5'd0;

        // ---- reset state ----
        cyc();
        cyc();
        #1;
        expect_rf("rst", 1'b0, 5'd0, 32'd0);
        check_eq("rst.rf_rdi", {27'd0, bus_if.rf_rdi}, 32'd0);
        check_eq("rst.rf_rd", bus_if.rf_rd, 32'd0);
        check_eq("rst.busy", bus_if.busy, 32'd0);
        check_eq("rst.md_ready", {31'd0, bus_if.md_ready}, 32'd0);
        check_eq("rst.issue_ready", {31'd0, bus_if.issue_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst.md_ready", {31'd0, bus_if.md_ready}, 32'd1);
        check_eq("post_rst.issue_ready", {31'd0, bus_if.issue_ready}, 32'd1);

        // ---- single pipeline writeback ----
        cyc();
        bus_if.wb_valid = 1'b1;
        bus_if.wb_rdi   = 5'd5;
        bus_if.wb_data  = 32'hDEADBEEF;
        cyc();
        bus_if.wb_valid = 1'b0;
        #1;
        expect_rf("wb5", 1'b1, 5'd5, 32'hDEADBEEF);
        cyc();
        expect_rf("wb5_after", 1'b0, 5'd0, 32'd0);

        // ---- issue / scoreboard / mul-div retire ----
        bus_if.issue_valid = 1'b1;
        bus_if.issue_rdi   = 5'd7;
        #1;
        check_eq("issue7.ready", {31'd0, bus_if.issue_ready}, 32'd1);
        cyc();
        bus_if.issue_valid = 1'b0;
        bus_if.rsi1 = 5'd7;
        bus_if.rsi2 = 5'd0;
        #1;
        check_eq("issue7.busy", bus_if.busy, 32'h0000_0080);
        check_eq("issue7.rs1_busy", {31'd0, bus_if.rs1_busy}, 32'd1);
        check_eq("issue7.rs2_busy", {31'd0, bus_if.rs2_busy}, 32'd0);
        check_eq("issue7.again_ready", {31'd0, bus_if.issue_ready}, 32'd0);
        bus_if.md_valid = 1'b1;
        bus_if.md_rdi   = 5'd7;
        bus_if.md_data  = 32'h12345678;
        cyc();
        bus_if.md_valid = 1'b0;
        #1;
        expect_rf("md7.n1", 1'b0, 5'd0, 32'd0);
        check_eq("md7.n1.busy", bus_if.busy, 32'h0000_0080);
        cyc();
        expect_rf("md7.n2", 1'b1, 5'd7, 32'h12345678);
        check_eq("md7.n2.busy", bus_if.busy, 32'd0);
        check_eq("md7.n2.rs1_busy", {31'd0, bus_if.rs1_busy}, 32'd0);
        cyc();
        expect_rf("md7.n3", 1'b0, 5'd0, 32'd0);

        // ---- pipeline contention with FIFO fill and drain ----
        bus_if.issue_valid = 1'b1;
        bus_if.issue_rdi   = 5'd9;
        cyc();
        bus_if.issue_rdi   = 5'd10;
        cyc();
        bus_if.issue_valid = 1'b0;
        #1;
        check_eq("cont.busy0", bus_if.busy, 32'h0000_0600);
        for (int i = 1; i <= 4; i++) begin
            bus_if.wb_valid = 1'b1;
            bus_if.wb_rdi   = 5'(i);
            bus_if.wb_data  = 32'h100 + 32'(i);
            bus_if.md_valid = (i <= 3);
            bus_if.md_rdi   = 5'(8 + i);
            bus_if.md_data  = 32'hA8 + 32'(i);
            #1;
            // two accepts then the FIFO is full
            check_eq($sformatf("cont.md_ready%0d", i), {31'd0, bus_if.md_ready}, (i <= 2) ? 32'd1 : 32'd0);
            if (i > 1) begin
                expect_rf($sformatf("cont.wb%0d", i - 1), 1'b1, 5'(i - 1), 32'h100 + 32'(i - 1));
            end
            cyc();
        end
        bus_if.wb_valid = 1'b0;
        bus_if.md_valid = 1'b0;
        #1;
        expect_rf("cont.wb4", 1'b1, 5'd4, 32'h104);
        cyc();
        expect_rf("cont.drain9", 1'b1, 5'd9, 32'hA9);
        check_eq("cont.busy9", bus_if.busy, 32'h0000_0400);
        cyc();
        expect_rf("cont.drain10", 1'b1, 5'd10, 32'hAA);
        check_eq("cont.busy10", bus_if.busy, 32'd0);
        cyc();
        expect_rf("cont.idle", 1'b0, 5'd0, 32'd0);
        check_eq("cont.md_ready_end", {31'd0, bus_if.md_ready}, 32'd1);

        // ---- outstanding limit ----
        for (int i = 1; i <= 4; i++) begin
            bus_if.issue_valid = 1'b1;
            bus_if.issue_rdi   = 5'(i);
            #1;
            check_eq($sformatf("lim.issue%0d", i), {31'd0, bus_if.issue_ready}, 32'd1);
            cyc();
        end
        bus_if.issue_valid = 1'b0;
        bus_if.issue_rdi   = 5'd5;
        #1;
        check_eq("lim.fifth", {31'd0, bus_if.issue_ready}, 32'd0);
        check_eq("lim.busy", bus_if.busy, 32'h0000_001E);
        bus_if.md_valid = 1'b1;
        bus_if.md_rdi   = 5'd1;
        bus_if.md_data  = 32'h0000_0111;
        cyc();
        bus_if.md_valid = 1'b0;
        #1;
        check_eq("lim.pop_cycle", {31'd0, bus_if.issue_ready}, 32'd0);
        cyc();
        check_eq("lim.after_retire", {31'd0, bus_if.issue_ready}, 32'd1);
        check_eq("lim.busy2", bus_if.busy, 32'h0000_001C);
        expect_rf("lim.rf1", 1'b1, 5'd1, 32'h0000_0111);
        // issue to x0 still counts toward the limit
        bus_if.issue_valid = 1'b1;
        bus_if.issue_rdi   = 5'd0;
        #1;
        check_eq("x0.issue_ready", {31'd0, bus_if.issue_ready}, 32'd1);
        cyc();
        bus_if.issue_valid = 1'b0;
        bus_if.issue_rdi   = 5'd5;
        #1;
        check_eq("x0.full_count", {31'd0, bus_if.issue_ready}, 32'd0);
        check_eq("x0.busy", bus_if.busy, 32'h0000_001C);

        // ---- writes to x0 ----
        bus_if.wb_valid = 1'b1;
        bus_if.wb_rdi   = 5'd0;
        bus_if.wb_data  = 32'h0000_0BAD;
        bus_if.md_valid = 1'b1;
        bus_if.md_rdi   = 5'd0;
        bus_if.md_data  = 32'h0000_BAD0;
        cyc();
        bus_if.wb_valid = 1'b0;
        bus_if.md_valid = 1'b0;
        #1;
        expect_rf("x0.wb", 1'b0, 5'd0, 32'd0);
        cyc();
        expect_rf("x0.md", 1'b0, 5'd0, 32'd0);
        check_eq("x0.retired", {31'd0, bus_if.issue_ready}, 32'd1);
        cyc();
        expect_rf("x0.idle", 1'b0, 5'd0, 32'd0);

        // ---- reset with 2 FIFO entries and 3 outstanding ----
        bus_if.wb_valid = 1'b1;
        bus_if.wb_rdi   = 5'd20;
        bus_if.wb_data  = 32'h14;
        bus_if.md_valid = 1'b1;
        bus_if.md_rdi   = 5'd2;
        bus_if.md_data  = 32'h2222;
        cyc();
        bus_if.wb_rdi   = 5'd21;
        bus_if.wb_data  = 32'h15;
        bus_if.md_rdi   = 5'd3;
        bus_if.md_data  = 32'h3333;
        #1;
        expect_rf("mrst.wb20", 1'b1, 5'd20, 32'h14);
        cyc();
        bus_if.wb_valid = 1'b0;
        bus_if.md_valid = 1'b0;
        #1;
        check_eq("mrst.full", {31'd0, bus_if.md_ready}, 32'd0);
        expect_rf("mrst.wb21", 1'b1, 5'd21, 32'h15);
        rst = 1'b1;
        cyc();
        expect_rf("mrst.rf", 1'b0, 5'd0, 32'd0);
        check_eq("mrst.busy", bus_if.busy, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("mrst.md_ready", {31'd0, bus_if.md_ready}, 32'd1);
        check_eq("mrst.issue_ready", {31'd0, bus_if.issue_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_rf($sformatf("mrst.quiet%0d", i), 1'b0, 5'd0, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
